maj_bist_driver: RTL and testbench

//  Self-test stage wrapped around the N-input majority gate (x0..x{N-1} -> y0).

---
 rtl/maj_bist_pkg.sv | 28 ++
 rtl/maj_ref_popcount.sv | 14 +
 rtl/maj_bist_driver.sv | 225 ++++++++++++++++++++++
 tb/tb_maj_bist_driver.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maj_bist_pkg.sv
// Shared types and helpers for the majority-gate self-test driver.
package maj_bist_pkg;

    // Run-control states of the BIST driver.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Widest vector the popcount helper accepts; narrower vectors are zero-extended.
    localparam int unsigned POP_W = 64;

    // x^33 + x^20 + 1, maximal-length Fibonacci feedback for the 33-bit default.
    localparam logic [32:0] DEFAULT_TAPS = 33'h1_0008_0000;

    // Number of ones in a (zero-extended) vector.
    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < POP_W; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/maj_ref_popcount.sv
// Golden majority reference: high when at least THRESH inputs are one.
module maj_ref_popcount
    import maj_bist_pkg::*;
#(
    parameter int unsigned N      = 33,
    parameter int unsigned THRESH = (N + 1) / 2
) (
    input  logic [N-1:0] i_x,
    output logic         o_ref
);

    assign o_ref = (popcount(POP_W'(i_x)) >= THRESH);

endmodule

// File: rtl/maj_bist_driver.sv
// Self-test driver for an N-input majority gate: issues exhaustive or LFSR
// vectors on o_x_out, checks the returned y against a popcount reference after
// DUT_LAT cycles, counts mismatches and captures the first failing vector.
module maj_bist_driver
    import maj_bist_pkg::*;
#(
    parameter int unsigned  N         = 33,
    parameter int unsigned  THRESH    = (N + 1) / 2,
    parameter int unsigned  DUT_LAT   = 0,
    parameter int unsigned  ERRW      = 16,
    parameter logic [N-1:0] LFSR_TAPS = N'(DEFAULT_TAPS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_mode_lfsr,
    input  logic [N-1:0]    i_seed,
    input  logic [N:0]      i_num_vecs,
    output logic [N-1:0]    o_x_out,
    input  logic            i_y_in,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [ERRW-1:0] o_err_count,
    output logic            o_first_fail_vld,
    output logic [N-1:0]    o_first_fail_vec
);

    localparam logic [N:0]      FULL_SPACE = {1'b1, {N{1'b0}}};
    localparam logic [N:0]      CNT_ONE    = {{N{1'b0}}, 1'b1};
    localparam logic [N-1:0]    X_ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0] ERR_ONE    = {{(ERRW-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0] ERR_MAX    = {ERRW{1'b1}};
    localparam int unsigned     DRW        = (DUT_LAT < 2) ? 1 : $clog2(DUT_LAT);
    localparam logic [DRW-1:0]  DRAIN_INIT = DRW'(DUT_LAT - 1);

    bist_state_e     r_state;
    logic [N-1:0]    r_x;
    logic [N:0]      r_remain;     // vectors still to issue after the current one
    logic            r_mode;
    logic [DRW-1:0]  r_drain;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [ERRW-1:0] r_err;
    logic            r_ff_vld;
    logic [N-1:0]    r_ff_vec;

    logic            w_start_acc;
    logic            w_abort_acc;
    logic [N:0]      w_nv_eff;
    logic [N-1:0]    w_first_vec;
    logic [N-1:0]    w_next_vec;
    logic            w_ref;
    logic            w_cmp_vld;
    logic            w_cmp_ref;
    logic [N-1:0]    w_cmp_x;
    logic            w_mismatch;
    logic [ERRW-1:0] w_err_next;
    logic            w_pass_next;

    // abort only matters while a run is in flight, and it beats a same-cycle start
    assign w_abort_acc = i_abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_start_acc = i_start && !i_abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // exhaustive mode cannot exceed the 2^N vector space; the LFSR simply keeps cycling
    assign w_nv_eff    = (!i_mode_lfsr && (i_num_vecs > FULL_SPACE)) ? FULL_SPACE : i_num_vecs;
    assign w_first_vec = i_mode_lfsr ? ((i_seed == '0) ? X_ONE : i_seed) : '0;
    assign w_next_vec  = r_mode ? {r_x[N-2:0], ^(r_x & LFSR_TAPS)} : (r_x + X_ONE);

    maj_ref_popcount #(
        .N      (N),
        .THRESH (THRESH)
    ) u_ref (
        .i_x   (r_x),
        .o_ref (w_ref)
    );

    generate
        if (DUT_LAT == 0) begin : g_no_pipe
            assign w_cmp_vld = (r_state == ST_RUN);
            assign w_cmp_ref = w_ref;
            assign w_cmp_x   = r_x;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] r_pvld;
            logic [DUT_LAT-1:0] r_pref;
            logic [N-1:0]       r_px [DUT_LAT];

            // Carry reference and vector alongside the DUT's own register stages
            always_ff @(posedge i_clk) begin
                if (i_rst || w_abort_acc) begin
                    r_pvld <= '0;
                    r_pref <= '0;
                    for (int i = 0; i < DUT_LAT; i++) begin
                        r_px[i] <= '0;
                    end
                end else begin
                    r_pvld[0] <= (r_state == ST_RUN);
                    r_pref[0] <= w_ref;
                    r_px[0]   <= r_x;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        r_pvld[i] <= r_pvld[i-1];
                        r_pref[i] <= r_pref[i-1];
                        r_px[i]   <= r_px[i-1];
                    end
                end
            end

            assign w_cmp_vld = r_pvld[DUT_LAT-1];
            assign w_cmp_ref = r_pref[DUT_LAT-1];
            assign w_cmp_x   = r_px[DUT_LAT-1];
        end
    endgenerate

    assign w_mismatch  = w_cmp_vld && (i_y_in != w_cmp_ref);
    assign w_err_next  = (r_err == ERR_MAX) ? r_err : (r_err + ERR_ONE);
    assign w_pass_next = (r_err == '0) && !w_mismatch;

    // Run-control FSM: vector generation, drain timing and status outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_remain <= '0;
            r_mode   <= 1'b0;
            r_drain  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_acc) begin
                        r_mode <= i_mode_lfsr;
                        r_pass <= 1'b0;
                        if (w_nv_eff == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_x     <= '0;
                        end else begin
                            r_state  <= ST_RUN;
                            r_done   <= 1'b0;
                            r_busy   <= 1'b1;
                            r_x      <= w_first_vec;
                            r_remain <= w_nv_eff - CNT_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_abort_acc) begin
                        r_state <= ST_IDLE;
                        r_x     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_remain == '0) begin
                        r_x <= '0;
                        if (DUT_LAT == 0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= w_pass_next;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_drain <= DRAIN_INIT;
                        end
                    end else begin
                        r_x      <= w_next_vec;
                        r_remain <= r_remain - CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_abort_acc) begin
                        r_state <= ST_IDLE;
                        r_x     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_drain == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= w_pass_next;
                    end else begin
                        r_drain <= r_drain - DRW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_x     <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating mismatch counter and first-failure capture; an aborting cycle's check is dropped
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_acc) begin
            r_err    <= '0;
            r_ff_vld <= 1'b0;
            r_ff_vec <= '0;
        end else if (w_mismatch && !w_abort_acc) begin
            r_err <= w_err_next;
            if (!r_ff_vld) begin
                r_ff_vld <= 1'b1;
                r_ff_vec <= w_cmp_x;
            end
        end
    end

    assign o_x_out          = r_x;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_count      = r_err;
    assign o_first_fail_vld = r_ff_vld;
    assign o_first_fail_vec = r_ff_vec;

endmodule

// File: tb/tb_maj_bist_driver.sv
// Bench for maj_bist_driver (N=7, DUT_LAT=2, ERRW=4) with a behavioural
// majority DUT that can be made faulty, a run-level reference model checked
// on every cycle, and a few hand-computed directed expectations.
module tb_maj_bist_driver;

    localparam int N      = 7;
    localparam int THRESH = 4;
    localparam int DL     = 2;
    localparam int ERRW   = 4;
    localparam int ERRMAX = 15;
    localparam logic [6:0] TAPS = 7'b1100000;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       mode_lfsr;
    logic [6:0] seed;
    logic [7:0] num_vecs;
    logic [6:0] x_out;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       ff_vld;
    logic [6:0] ff_vec;

    int n_checks;
    int n_errs;

    maj_bist_driver #(
        .N         (N),
        .THRESH    (THRESH),
        .DUT_LAT   (DL),
        .ERRW      (ERRW),
        .LFSR_TAPS (TAPS)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_abort          (abort),
        .i_mode_lfsr      (mode_lfsr),
        .i_seed           (seed),
        .i_num_vecs       (num_vecs),
        .o_x_out          (x_out),
        .i_y_in           (dut_y),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass           (pass),
        .o_err_count      (err_count),
        .o_first_fail_vld (ff_vld),
        .o_first_fail_vec (ff_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural majority gate under test: 2 register stages; fault 1 = stuck-0, 2 = 3 stages
    int         fault;
    logic [3:0] maj_sr;
    always @(posedge clk) maj_sr <= {maj_sr[2:0], ($countones(x_out) >= THRESH)};
    always_comb begin
        case (fault)
            1:       dut_y = 1'b0;
            2:       dut_y = maj_sr[2];
            default: dut_y = maj_sr[1];
        endcase
    end

    // Reference model: a run is described by its vector list and the cycle index since start
    bit         m_run;
    int         m_c;
    int         m_nv;
    logic [6:0] m_vecs [256];
    bit         m_done;
    bit         m_pass;
    int         m_err;
    bit         m_ffv;
    logic [6:0] m_ffvec;

    task automatic model_reset();
        m_run = 0; m_c = 0; m_nv = 0; m_done = 0; m_pass = 0;
        m_err = 0; m_ffv = 0; m_ffvec = 7'd0;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the next edge
    task automatic check_cycle();
        logic [6:0] exp_x;
        logic [6:0] v;
        int         nv;
        int         k;
        bit         refv;
        exp_x = (m_run && m_c <= m_nv) ? m_vecs[m_c-1] : 7'd0;
        cmp("x_out",          32'(x_out),     32'(exp_x));
        cmp("busy",           32'(busy),      32'(m_run));
        cmp("done",           32'(done),      32'(m_done));
        cmp("pass",           32'(pass),      32'(m_pass));
        cmp("err_count",      32'(err_count), 32'(m_err));
        cmp("first_fail_vld", 32'(ff_vld),    32'(m_ffv));
        cmp("first_fail_vec", 32'(ff_vec),    32'(m_ffvec));
        if (rst) begin
            model_reset();
        end else if (m_run) begin
            if (abort) begin
                m_run = 0; m_done = 0; m_pass = 0;
            end else begin
                if (m_c >= DL + 1 && m_c <= m_nv + DL) begin
                    k    = m_c - 1 - DL;
                    refv = ($countones(m_vecs[k]) >= THRESH);
                    if (dut_y != refv) begin
                        if (m_err < ERRMAX) m_err++;
                        if (!m_ffv) begin
                            m_ffv = 1; m_ffvec = m_vecs[k];
                        end
                    end
                end
                m_c++;
                if (m_c > m_nv + DL) begin
                    m_run = 0; m_done = 1; m_pass = (m_err == 0);
                end
            end
        end else if (start && !abort) begin
            m_err = 0; m_ffv = 0; m_ffvec = 7'd0; m_done = 0; m_pass = 0;
            nv = int'(num_vecs);
            if (!mode_lfsr && nv > 128) nv = 128;
            m_nv = nv;
            v = mode_lfsr ? ((seed == 7'd0) ? 7'd1 : seed) : 7'd0;
            for (int i = 0; i < nv; i++) begin
                m_vecs[i] = v;
                if (mode_lfsr) v = {v[5:0], ^(v & TAPS)};
                else           v = v + 7'd1;
            end
            if (nv == 0) begin
                m_done = 1; m_pass = 1;
            end else begin
                m_run = 1; m_c = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic md, input logic [6:0] sd, input logic [7:0] nv);
        start = 1'b1; mode_lfsr = md; seed = sd; num_vecs = nv;
        tick();
        start = 1'b0;
        mode_lfsr = 1'($urandom_range(0, 1));
        seed      = 7'($urandom_range(0, 127));
        num_vecs  = 8'($urandom_range(0, 255));
    endtask

    // Advance until done (returns its cycle) or until the abort cycle has been applied
    task automatic wait_done(input int c0, input int abort_at, input int spur_at, output int done_cyc);
        int c;
        bit fin;
        c = c0; fin = 0; done_cyc = -1;
        while (!fin && c < 400) begin
            if (done) begin
                fin = 1; done_cyc = c;
            end else begin
                abort = (c == abort_at);
                start = (c == spur_at);
                tick();
                abort = 1'b0; start = 1'b0;
                if (c == abort_at) fin = 1;
                c++;
            end
        end
        n_checks++;
        if (!fin) begin
            n_errs++;
            $display("FAIL run_timeout: got no done after %0d cycles, required done", c);
        end
    endtask

    initial begin
        int dc;
        int sel;
        int nv;
        int ab;
        int sp;
        logic md;
        n_checks = 0; n_errs = 0; fault = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode_lfsr = 1'b0; seed = 7'd0; num_vecs = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_x_out", 32'(x_out), 32'd0);
        cmp("rst_busy",  32'(busy),  32'd0);
        cmp("rst_done",  32'(done),  32'd0);
        cmp("rst_pass",  32'(pass),  32'd0);
        cmp("rst_err",   32'(err_count), 32'd0);
        cmp("rst_ffv",   32'(ff_vld), 32'd0);
        cmp("rst_ffvec", 32'(ff_vec), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // full exhaustive sweep, ideal gate
        start_run(1'b0, 7'd0, 8'd128);
        cmp("exh_x_v0", 32'(x_out), 32'd0);
        tick();
        cmp("exh_x_v1", 32'(x_out), 32'd1);
        wait_done(2, -1, -1, dc);
        cmp("exh_done_cycle", 32'(dc), 32'd131);
        cmp("exh_pass", 32'(pass), 32'd1);
        cmp("exh_err",  32'(err_count), 32'd0);

        // stuck-0 output: 64 mismatches saturate the 4-bit counter
        fault = 1;
        start_run(1'b0, 7'd0, 8'd128);
        wait_done(1, -1, -1, dc);
        cmp("stuck_err_sat", 32'(err_count), 32'd15);
        cmp("stuck_ffv",     32'(ff_vld), 32'd1);
        cmp("stuck_ffvec",   32'(ff_vec), 32'b0001111);
        cmp("stuck_pass",    32'(pass), 32'd0);

        // zero-length run
        fault = 0;
        start_run(1'b0, 7'd0, 8'd0);
        wait_done(1, -1, -1, dc);
        cmp("nv0_done_cycle", 32'(dc), 32'd1);
        cmp("nv0_pass", 32'(pass), 32'd1);

        // LFSR: zero seed becomes 1; seed 64 exercises the feedback tap
        start_run(1'b1, 7'd0, 8'd5);
        cmp("lfsr0_x_v0", 32'(x_out), 32'd1);
        tick();
        cmp("lfsr0_x_v1", 32'(x_out), 32'd2);
        wait_done(2, -1, -1, dc);
        cmp("lfsr0_done_cycle", 32'(dc), 32'd8);
        start_run(1'b1, 7'd64, 8'd4);
        cmp("lfsr64_x_v0", 32'(x_out), 32'd64);
        tick();
        cmp("lfsr64_x_v1", 32'(x_out), 32'd1);
        tick();
        cmp("lfsr64_x_v2", 32'(x_out), 32'd2);
        wait_done(3, -1, -1, dc);

        // abort at cycle 10, then a clean run
        start_run(1'b0, 7'd0, 8'd100);
        wait_done(1, 10, -1, dc);
        cmp("abort_busy", 32'(busy),  32'd0);
        cmp("abort_done", 32'(done),  32'd0);
        cmp("abort_x",    32'(x_out), 32'd0);
        start_run(1'b0, 7'd0, 8'd20);
        wait_done(1, -1, -1, dc);
        cmp("after_abort_done_cycle", 32'(dc), 32'd23);
        cmp("after_abort_pass", 32'(pass), 32'd1);

        // exhaustive request beyond 2^N is clamped
        start_run(1'b0, 7'd0, 8'd200);
        wait_done(1, -1, -1, dc);
        cmp("clamp_done_cycle", 32'(dc), 32'd131);

        // DUT one stage slower than expected must be caught
        fault = 2;
        start_run(1'b0, 7'd0, 8'd50);
        wait_done(1, -1, -1, dc);
        cmp("delay_err_nonzero", 32'(err_count != 4'd0), 32'd1);
        cmp("delay_pass", 32'(pass), 32'd0);

        // reset in the middle of a failing run
        fault = 1;
        start_run(1'b1, 7'h7F, 8'd50);
        repeat (5) tick();
        cmp("midrun_err", 32'(err_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("midrst_busy", 32'(busy), 32'd0);
        cmp("midrst_err",  32'(err_count), 32'd0);
        cmp("midrst_x",    32'(x_out), 32'd0);
        tick();

        // randomized runs against the model
        for (int r = 0; r < 40; r++) begin
            sel   = $urandom_range(0, 9);
            fault = (sel < 6) ? 0 : ((sel < 8) ? 1 : 2);
            md    = 1'($urandom_range(0, 1));
            sel   = $urandom_range(0, 9);
            case (sel)
                0:       nv = 0;
                1:       nv = 128;
                2:       nv = 200;
                3:       nv = 255;
                default: nv = $urandom_range(1, 40);
            endcase
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nv + 3) : -1;
            sp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nv + 3) : -1;
            if ($urandom_range(0, 7) == 0) sp = ab;
            seed = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            start_run(md, seed, 8'(nv));
            wait_done(1, ab, sp, dc);
            repeat ($urandom_range(0, 2)) begin
                abort = 1'($urandom_range(0, 1));
                tick();
                abort = 1'b0;
            end
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
